// File: rtl/rv_writeback.sv
// Writeback stage: selects the register-file result for ALU/shift/multiply ops and
// waits on data memory for loads and stores, with a bounded wait that raises a bus error.
module rv_writeback #(
    parameter int g_mem_timeout = 63
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        w_valid_i,
    input  logic [2:0]  w_fun_i,
    input  logic        w_load_i,
    input  logic        w_store_i,
    input  logic [4:0]  w_rd_i,
    input  logic        w_rd_write_i,
    input  logic [31:0] w_rd_value_i,
    input  logic [1:0]  w_rd_source_i,
    input  logic [31:0] w_rd_shifter_i,
    input  logic [31:0] w_rd_multiply_i,
    input  logic [31:0] w_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    input  logic        dm_store_done_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_stall_req_o,
    output logic        w_bus_error_o
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_MEM
    } state_t;

    localparam logic [7:0] LP_TMO_LAST = 8'(g_mem_timeout - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [4:0]  r_rd;
    logic [2:0]  r_fun;
    logic [1:0]  r_lane;
    logic        r_rd_write;
    logic        r_is_load;

    logic        w_accept;
    logic        w_done_in;
    logic        w_done_wait;
    logic        w_in_wait;
    logic        w_timeout;
    logic        w_unused_addr;

    function automatic logic [31:0] f_result(
        input logic [1:0]  src,
        input logic [31:0] value,
        input logic [31:0] shifter,
        input logic [31:0] multiply
    );
        case (src)
            2'b01:   f_result = shifter;
            2'b10:   f_result = multiply;
            default: f_result = value;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(
        input logic [2:0]  fun,
        input logic [1:0]  lane,
        input logic [31:0] data
    );
        logic signed [7:0]  v_byte;
        logic signed [15:0] v_half;
        logic signed [31:0] v_ext_b;
        logic signed [31:0] v_ext_h;
        case (lane)
            2'b00:   v_byte = data[7:0];
            2'b01:   v_byte = data[15:8];
            2'b10:   v_byte = data[23:16];
            default: v_byte = data[31:24];
        endcase
        v_half  = lane[1] ? data[31:16] : data[15:0];
        v_ext_b = v_byte;
        v_ext_h = v_half;
        case (fun)
            3'b000:  f_load_extract = v_ext_b;
            3'b001:  f_load_extract = v_ext_h;
            3'b100:  f_load_extract = {24'd0, v_byte};
            3'b101:  f_load_extract = {16'd0, v_half};
            default: f_load_extract = data;
        endcase
    endfunction

    // Only the byte lane of the address matters here; the rest is the memory stage's business.
    assign w_unused_addr = ^w_dm_addr_i[31:2];

    assign w_in_wait   = (r_state == ST_WAIT_MEM);
    assign w_accept    = (r_state == ST_IDLE) & w_valid_i & (w_load_i | w_store_i);
    assign w_done_in   = w_load_i ? dm_load_done_i : dm_store_done_i;
    assign w_done_wait = r_is_load ? dm_load_done_i : dm_store_done_i;
    assign w_timeout   = w_in_wait & ~w_done_wait & (r_cnt == LP_TMO_LAST);

    assign w_stall_req_o = (w_accept & ~w_done_in) | (w_in_wait & ~w_done_wait & ~w_timeout);

    // Access descriptor held while the memory is outstanding.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_rd       <= w_rd_i;
            r_fun      <= w_fun_i;
            r_lane     <= w_dm_addr_i[1:0];
            r_rd_write <= w_rd_write_i;
            r_is_load  <= w_load_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            rf_rd_o       <= 5'd0;
            rf_rd_value_o <= 32'd0;
            rf_rd_write_o <= 1'b0;
            w_bus_error_o <= 1'b0;
        end else begin
            rf_rd_write_o <= 1'b0;
            w_bus_error_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= 8'd0;
                        if (w_done_in) begin
                            if (w_load_i) begin
                                rf_rd_o       <= w_rd_i;
                                rf_rd_value_o <= f_load_extract(w_fun_i, w_dm_addr_i[1:0], dm_data_l_i);
                                rf_rd_write_o <= w_rd_write_i & (w_rd_i != 5'd0);
                            end
                        end else begin
                            r_state <= ST_WAIT_MEM;
                        end
                    end else if (w_valid_i) begin
                        rf_rd_o       <= w_rd_i;
                        rf_rd_value_o <= f_result(w_rd_source_i, w_rd_value_i,
                                                  w_rd_shifter_i, w_rd_multiply_i);
                        rf_rd_write_o <= w_rd_write_i & (w_rd_i != 5'd0);
                    end
                end
                ST_WAIT_MEM: begin
                    if (w_done_wait) begin
                        r_state <= ST_IDLE;
                        if (r_is_load) begin
                            rf_rd_o       <= r_rd;
                            rf_rd_value_o <= f_load_extract(r_fun, r_lane, dm_data_l_i);
                            rf_rd_write_o <= r_rd_write & (r_rd != 5'd0);
                        end
                    end else if (w_timeout) begin
                        r_state       <= ST_IDLE;
                        w_bus_error_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_writeback.sv
// Scoreboard bench for rv_writeback: stimulus pushes expected rf writes and bus errors,
// a monitor pops them whenever the DUT presents a write or an error pulse.
module tb_rv_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        w_valid_i;
    logic [2:0]  w_fun_i;
    logic        w_load_i;
    logic        w_store_i;
    logic [4:0]  w_rd_i;
    logic        w_rd_write_i;
    logic [31:0] w_rd_value_i;
    logic [1:0]  w_rd_source_i;
    logic [31:0] w_rd_shifter_i;
    logic [31:0] w_rd_multiply_i;
    logic [31:0] w_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        dm_store_done_i;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic        w_stall_req_o;
    logic        w_bus_error_o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t q_exp[$];
    int   exp_berr = 0;
    int   checks   = 0;
    int   errors   = 0;

    rv_writeback #(.g_mem_timeout(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .w_valid_i       (w_valid_i),
        .w_fun_i         (w_fun_i),
        .w_load_i        (w_load_i),
        .w_store_i       (w_store_i),
        .w_rd_i          (w_rd_i),
        .w_rd_write_i    (w_rd_write_i),
        .w_rd_value_i    (w_rd_value_i),
        .w_rd_source_i   (w_rd_source_i),
        .w_rd_shifter_i  (w_rd_shifter_i),
        .w_rd_multiply_i (w_rd_multiply_i),
        .w_dm_addr_i     (w_dm_addr_i),
        .dm_data_l_i     (dm_data_l_i),
        .dm_load_done_i  (dm_load_done_i),
        .dm_store_done_i (dm_store_done_i),
        .rf_rd_o         (rf_rd_o),
        .rf_rd_value_o   (rf_rd_value_o),
        .rf_rd_write_o   (rf_rd_write_o),
        .w_stall_req_o   (w_stall_req_o),
        .w_bus_error_o   (w_bus_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        w_valid_i       = 1'b0;
        w_fun_i         = 3'b000;
        w_load_i        = 1'b0;
        w_store_i       = 1'b0;
        w_rd_i          = 5'd0;
        w_rd_write_i    = 1'b0;
        w_rd_value_i    = 32'd0;
        w_rd_source_i   = 2'b00;
        w_rd_shifter_i  = 32'd0;
        w_rd_multiply_i = 32'd0;
        w_dm_addr_i     = 32'd0;
        dm_data_l_i     = 32'd0;
        dm_load_done_i  = 1'b0;
        dm_store_done_i = 1'b0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.rd  = rd;
        e.val = val;
        q_exp.push_back(e);
    endtask

    // Non-memory op; distinct operands on each source so a wrong mux leg shows up.
    task automatic alu(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] exp_val);
        w_valid_i       = 1'b1;
        w_rd_i          = rd;
        w_rd_write_i    = 1'b1;
        w_rd_source_i   = src;
        w_rd_value_i    = 32'h0000_1234;
        w_rd_shifter_i  = 32'hA5A5_0F0F;
        w_rd_multiply_i = 32'h1357_9BDF;
        @(negedge clk_i);
        chk("alu_stall", 32'(w_stall_req_o), 32'd0);
        if (rd != 5'd0) push(rd, exp_val);
        cyc();
        drive_idle();
    endtask

    task automatic load_now(input logic [2:0] fun, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] rd,
                            input logic [31:0] exp_val);
        w_valid_i      = 1'b1;
        w_load_i       = 1'b1;
        w_fun_i        = fun;
        w_dm_addr_i    = addr;
        w_rd_i         = rd;
        w_rd_write_i   = 1'b1;
        dm_data_l_i    = data;
        dm_load_done_i = 1'b1;
        @(negedge clk_i);
        chk("load_now_stall", 32'(w_stall_req_o), 32'd0);
        push(rd, exp_val);
        cyc();
        drive_idle();
    endtask

    // Monitor: every registered output is checked against the scoreboard.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rf_rd_write_o) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("rf_rd", 32'(rf_rd_o), 32'(e.rd));
                    chk("rf_value", rf_rd_value_o, e.val);
                end
            end
            if (w_bus_error_o) begin
                chk("bus_error_expected", 32'(exp_berr > 0), 32'd1);
                if (exp_berr > 0) exp_berr--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        drive_idle();
        cyc();
        cyc();
        chk("rst_rd", 32'(rf_rd_o), 32'd0);
        chk("rst_value", rf_rd_value_o, 32'd0);
        chk("rst_write", 32'(rf_rd_write_o), 32'd0);
        chk("rst_berr", 32'(w_bus_error_o), 32'd0);
        chk("rst_stall", 32'(w_stall_req_o), 32'd0);
        rst_i = 1'b0;
        cyc();

        // Non-memory results from each source.
        alu(5'd5, 2'b00, 32'h0000_1234);
        alu(5'd6, 2'b01, 32'hA5A5_0F0F);
        alu(5'd7, 2'b10, 32'h1357_9BDF);
        alu(5'd0, 2'b10, 32'h1357_9BDF);
        chk("rd0_value_updated", rf_rd_value_o, 32'h1357_9BDF);
        chk("rd0_no_write", 32'(rf_rd_write_o), 32'd0);

        // LB from lane 3 with three wait cycles; inputs change meanwhile and must be ignored.
        w_valid_i    = 1'b1;
        w_load_i     = 1'b1;
        w_fun_i      = 3'b000;
        w_dm_addr_i  = 32'h0000_1003;
        w_rd_i       = 5'd7;
        w_rd_write_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("lb_stall", 32'(w_stall_req_o), 32'd1);
            cyc();
            w_rd_i      = 5'd9;
            w_fun_i     = 3'b010;
            w_dm_addr_i = 32'h0000_1000;
        end
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h80FF_FFFF;
        @(negedge clk_i);
        chk("lb_done_stall", 32'(w_stall_req_o), 32'd0);
        push(5'd7, 32'hFFFF_FF80);
        cyc();
        drive_idle();

        // Same-cycle loads of every width.
        load_now(3'b101, 32'h0000_2002, 32'hBEEF_0000, 5'd3, 32'h0000_BEEF);
        load_now(3'b001, 32'h0000_2000, 32'h1234_8001, 5'd4, 32'hFFFF_8001);
        load_now(3'b100, 32'h0000_2001, 32'h0000_F000, 5'd8, 32'h0000_00F0);
        load_now(3'b010, 32'h0000_2000, 32'hCAFE_F00D, 5'd9, 32'hCAFE_F00D);
        load_now(3'b001, 32'h0000_2002, 32'h7FFE_0000, 5'd10, 32'h0000_7FFE);

        // Store completing after two cycles of stall; no rf write may appear.
        w_valid_i    = 1'b1;
        w_store_i    = 1'b1;
        w_rd_i       = 5'd4;
        w_rd_write_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("store_stall", 32'(w_stall_req_o), 32'd1);
            cyc();
        end
        dm_store_done_i = 1'b1;
        @(negedge clk_i);
        chk("store_done_stall", 32'(w_stall_req_o), 32'd0);
        cyc();
        drive_idle();
        chk("store_no_write", 32'(rf_rd_write_o), 32'd0);

        // Load timeout: four stall cycles, release on the timeout cycle, then one error pulse.
        w_valid_i    = 1'b1;
        w_load_i     = 1'b1;
        w_rd_i       = 5'd11;
        w_rd_write_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("tmo_stall", 32'(w_stall_req_o), 32'd1);
            cyc();
        end
        @(negedge clk_i);
        chk("tmo_release", 32'(w_stall_req_o), 32'd0);
        chk("tmo_berr_not_yet", 32'(w_bus_error_o), 32'd0);
        exp_berr = 1;
        cyc();
        drive_idle();
        alu(5'd1, 2'b00, 32'h0000_1234);
        chk("tmo_berr_cleared", 32'(w_bus_error_o), 32'd0);

        // Reset while waiting on memory; a late done must be ignored.
        w_valid_i    = 1'b1;
        w_load_i     = 1'b1;
        w_fun_i      = 3'b010;
        w_rd_i       = 5'd12;
        w_rd_write_i = 1'b1;
        @(negedge clk_i);
        chk("rstw_stall0", 32'(w_stall_req_o), 32'd1);
        cyc();
        @(negedge clk_i);
        chk("rstw_stall1", 32'(w_stall_req_o), 32'd1);
        #2;
        rst_i = 1'b1;
        drive_idle();
        #1;
        chk("rstw_rd", 32'(rf_rd_o), 32'd0);
        chk("rstw_value", rf_rd_value_o, 32'd0);
        chk("rstw_stall", 32'(w_stall_req_o), 32'd0);
        cyc();
        rst_i          = 1'b0;
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("late_done_stall", 32'(w_stall_req_o), 32'd0);
        cyc();
        drive_idle();
        cyc();
        chk("late_done_rd", 32'(rf_rd_o), 32'd0);
        chk("late_done_value", rf_rd_value_o, 32'd0);
        chk("late_done_write", 32'(rf_rd_write_o), 32'd0);
        chk("late_done_berr", 32'(w_bus_error_o), 32'd0);

        cyc();
        cyc();
        chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        chk("bus_errors_seen", 32'(exp_berr), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_writeback.md
RV_WRITEBACK -- requirements
Module: rv_writeback

Interface
REQ-001 SHALL have parameter g_mem_timeout, default 63, meaning the number of cycles spent in WAIT_MEM without a done before the access is abandoned (legal range 1..255).
REQ-002 SHALL have port clk_i  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port w_valid_i  in  1  execute-stage result valid.
REQ-005 SHALL have port w_fun_i  in  3  load width/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 SHALL have port w_load_i  in  1  load issued by execute.
REQ-007 SHALL have port w_store_i  in  1  store issued by execute.
REQ-008 SHALL have port w_rd_i  in  5  destination register index.
REQ-009 SHALL have port w_rd_write_i  in  1  destination write enable.
REQ-010 SHALL have port w_rd_value_i  in  32  ALU/CSR result.
REQ-011 SHALL have port w_rd_source_i  in  2  result source: 00 value, 01 shifter, 10 multiply, 11 load.
REQ-012 SHALL have port w_rd_shifter_i  in  32  shifter result.
REQ-013 SHALL have port w_rd_multiply_i  in  32  multiplier result.
REQ-014 SHALL have port w_dm_addr_i  in  32  data-memory byte address.
REQ-015 SHALL have port dm_data_l_i  in  32  load data, valid while dm_load_done_i=1.
REQ-016 SHALL have port dm_load_done_i  in  1  load completion strobe.
REQ-017 SHALL have port dm_store_done_i  in  1  store completion strobe.
REQ-018 SHALL have port rf_rd_o  out  5  register-file write index.
REQ-019 SHALL have port rf_rd_value_o  out  32  register-file write data.
REQ-020 SHALL have port rf_rd_write_o  out  1  register-file write strobe.
REQ-021 SHALL have port w_stall_req_o  out  1  combinational pipeline stall request.
REQ-022 SHALL have port w_bus_error_o  out  1  one-cycle pulse on memory timeout.

Function
REQ-023 SHALL implement an FSM with states IDLE and WAIT_MEM.
REQ-024 SHALL treat an access as accepted in IDLE when w_valid_i & (w_load_i | w_store_i).
REQ-025 SHALL capture w_rd_i, w_fun_i, w_dm_addr_i[1:0], w_rd_write_i and load/store type when an access is accepted.
REQ-026 SHALL complete an access when the matching done signal (dm_load_done_i for loads, dm_store_done_i for stores) is high.
REQ-027 SHALL complete an accepted access in the same cycle without leaving IDLE when the matching done is already high on acceptance.
REQ-028 SHALL otherwise move IDLE->WAIT_MEM on acceptance, and move WAIT_MEM->IDLE on completion or timeout.
REQ-029 SHALL drive w_stall_req_o = (accepted in IDLE & !done) | (WAIT_MEM & !done & !timeout); the stall is released in the completing cycle.
REQ-030 SHALL clear an 8-bit wait counter on acceptance and increment it each WAIT_MEM cycle without a done.
REQ-031 SHALL detect timeout when the counter equals g_mem_timeout-1 with no done, return to IDLE, pulse w_bus_error_o the following cycle, and perform no rf write.
REQ-032 SHALL register all rf outputs, so data appears one cycle after the completing/accepting edge.
REQ-033 SHALL, for a non-memory op, assert rf_rd_write_o = w_valid_i & w_rd_write_i, with rf_rd_value_o selected by w_rd_source_i (00, 01 or 10).
REQ-034 SHALL extract load bytes at lane w_dm_addr[1:0] and halfwords at lane w_dm_addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, and any other code passes dm_data_l_i unchanged.
REQ-035 SHALL complete stores without any rf write.
REQ-036 SHALL ignore new inputs while in WAIT_MEM, since execute is stalled.
REQ-037 SHALL force rf_rd_write_o to 0 when the captured rd is 0, while still updating rf_rd_value_o.
REQ-038 SHALL deassert rf_rd_write_o in every cycle with no completing write.

Reset
REQ-039 SHALL, on rst_i, asynchronously force state IDLE, counter 0, and rf_rd_o, rf_rd_value_o, rf_rd_write_o, w_bus_error_o all 0.
REQ-040 SHALL abandon an access in progress when reset is applied mid-WAIT_MEM; a late done after reset release is ignored.

Verification
REQ-041 SHALL cover an ALU op: valid, rd=5, source 00, value 0x1234 -> next cycle rf_rd_o=5, value 0x1234, write=1, no stall.
REQ-042 SHALL cover LB with a 3-cycle delay: addr 0x..3, data 0x80FFFFFF, done on cycle 3 -> stall high for cycles 0-2, then rf value 0xFFFFFF80.
REQ-043 SHALL cover LHU with the same-cycle done: addr 0x..2, data 0xBEEF0000 -> no stall, rf value 0x0000BEEF.
REQ-044 SHALL cover a store: done after 2 cycles -> stall for 2 cycles, rf_rd_write_o stays 0.
REQ-045 SHALL cover a load timeout with g_mem_timeout=4 and no done -> stall for 4 cycles, one-cycle w_bus_error_o pulse, no rf write, FSM returns to IDLE.
REQ-046 SHALL cover reset in WAIT_MEM, then done after release -> all outputs 0, no write, stall 0.
